mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Performs data-memory loads and stores over a req/ack bus that has variable wait states.
- Stalls upstream stages while an access is outstanding.
- Registers the selected write-back data into the MEM/WB boundary for the register file.

Parameters:
- TIMEOUT_CYCLES, 16, max REQ-state cycles without ack before abort (used only when ACCESS_TIMEOUT_EN is defined); legal range 1..255.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-low (rst==0 resets on clk rising edge)
- MEMDramWriteEnable  input  1  store request
- MEMRegisterFileWriteEnable  input  1  instruction writes register file
- MEMRegisterFileWriteSelect  input  2  WB source: 00 ALU, 01 load data, 10 Pc4, 11 Ext
- MEMWriteRegister  input  5  destination register
- MEMPc4  input  32  PC+4
- MEMAluResult  input  32  byte address / ALU value
- MEMRegisterData2  input  32  store data
- MEMExt  input  32  immediate
- MEMStall  output  1  hold EX/MEM and earlier stages
- bus_req  output  1  access request, registered
- bus_we  output  1  1=store, 0=load, registered
- bus_addr  output  32  word address {MEMAluResult[31:2],2'b00}, registered
- bus_wdata  output  32  store data, registered
- bus_ack  input  1  access complete, one cycle pulse
- bus_rdata  input  32  load data, valid with bus_ack
- WBRegisterFileWriteEnable  output  1  registered
- WBWriteRegister  output  5  registered
- WBWriteData  output  32  registered
- MEMBusError  output  1  sticky timeout flag

Behaviour:
- Access needed (acc) = MEMDramWriteEnable | (MEMRegisterFileWriteSelect==01). Store takes priority for bus_we if both are set.
- FSM states IDLE, REQ, DONE. Reset state is IDLE.
- IDLE:
  - MEMStall = acc (combinational).
  - If acc: next state REQ; bus_req<=1; bus_we, bus_addr, bus_wdata loaded from MEM inputs.
  - Else stay IDLE.
- REQ:
  - MEMStall=1; bus outputs held stable.
  - On bus_ack==1: capture bus_rdata into load buffer; bus_req<=0; next state DONE.
- DONE:
  - MEMStall=0; WB capture uses load buffer for select 01.
  - Next state IDLE unconditionally, so the next instruction is evaluated fresh and the same access is not reissued.
- bus_ack is ignored in IDLE and DONE.
- WB register, every edge:
  - If MEMStall==0: WB* <= MEM fields; WBWriteData per select mux.
  - If MEMStall==1: WBRegisterFileWriteEnable<=0 (bubble); WBWriteRegister and WBWriteData hold.
- Latency:
  - Non-access instruction: WB valid 1 edge after arrival.
  - Access with ack N cycles after bus_req rises (N>=1): bus_req rises 1 edge after arrival, WB valid N+2 edges after arrival; MEMStall high N+1 cycles.
  - Ack in first REQ cycle is legal.
- Stores with MEMRegisterFileWriteEnable=1 and select!=01 write back the muxed value as normal.
- Address bits [1:0] are dropped; no misalignment trap.
- Reset (rst==0), any state including REQ mid-access:
  - Next edge: state IDLE; bus_req, bus_we, bus_addr, bus_wdata = 0; WB* = 0; load buffer = 0; MEMBusError = 0.
  - A late ack after reset is ignored.

Optional Feature:
- Macro ACCESS_TIMEOUT_EN.
- Defined:
  - 8-bit counter cleared on entry to REQ, increments each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYCLES: bus_req<=0; load buffer<=32'h0; MEMBusError<=1 (sticky until reset); next state DONE, where the instruction retires.
  - Ack on the same cycle as timeout wins: normal completion, no error.
- Undefined: no counter; REQ waits indefinitely; MEMBusError tied 0.

Test Plan:
- Reset: rst=0 for 2 cycles with random inputs -> all outputs 0, state IDLE, MEMStall=0 when acc=0.
- ALU op: select=00, MEMAluResult=32'h1234, WE=1, reg=5 -> next edge WBWriteData=32'h1234, WBWriteRegister=5, WB WE=1, MEMStall never high.
- Load, ack 3 cycles after req: MEMAluResult=32'h1003, select=01 -> bus_addr=32'h1000, bus_we=0, MEMStall high 4 cycles, WBWriteData=bus_rdata (32'hCAFEF00D) on the edge after DONE, exactly one bus_req pulse train.
- Store: MEMDramWriteEnable=1, MEMRegisterData2=32'hA5A5A5A5, ack in first REQ cycle -> bus_we=1, bus_wdata=32'hA5A5A5A5, MEMStall high 2 cycles, WB WE=0 during stall.
- Reset mid-REQ, then ack arrives -> bus_req=0 after the reset edge, ack ignored, no WB write.
- ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never arrives -> bus_req drops after 4 REQ cycles, MEMBusError=1 and stays 1, WBWriteData=0 for the load.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues req/ack data-memory accesses, stalls upstream, registers MEM/WB.
// Optional ACCESS_TIMEOUT_EN aborts a REQ after TIMEOUT_CYCLES cycles without ack and sets MEMBusError.
`timescale 1ns/1ps
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEMDramWriteEnable,
    input  logic        MEMRegisterFileWriteEnable,
    input  logic [1:0]  MEMRegisterFileWriteSelect,
    input  logic [4:0]  MEMWriteRegister,
    input  logic [31:0] MEMPc4,
    input  logic [31:0] MEMAluResult,
    input  logic [31:0] MEMRegisterData2,
    input  logic [31:0] MEMExt,
    output logic        MEMStall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        WBRegisterFileWriteEnable,
    output logic [4:0]  WBWriteRegister,
    output logic [31:0] WBWriteData,
    output logic        MEMBusError
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;
    localparam int unsigned SELW = 2;
    localparam int unsigned CNTW = 8;

    localparam logic [SELW-1:0] SEL_ALU  = 2'b00;
    localparam logic [SELW-1:0] SEL_LOAD = 2'b01;
    localparam logic [SELW-1:0] SEL_PC4  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [XLEN-1:0]   bus_addr_q, bus_addr_d;
    logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
    logic [XLEN-1:0]   ld_buf_q, ld_buf_d;
    logic              wb_we_q, wb_we_d;
    logic [REGW-1:0]   wb_reg_q, wb_reg_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              acc;
    logic              stall;
    logic [XLEN-1:0]   wb_mux;

`ifdef ACCESS_TIMEOUT_EN
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
`else
    logic [CNTW-1:0]   unused_timeout;
    assign unused_timeout = CNTW'(TIMEOUT_CYCLES);
`endif

    assign acc = MEMDramWriteEnable | (MEMRegisterFileWriteSelect == SEL_LOAD);

    // Write-back source select; load data always comes from the captured buffer
    always_comb begin
        wb_mux = MEMExt;
        case (MEMRegisterFileWriteSelect)
            SEL_ALU:  wb_mux = MEMAluResult;
            SEL_LOAD: wb_mux = ld_buf_q;
            SEL_PC4:  wb_mux = MEMPc4;
            default:  wb_mux = MEMExt;
        endcase
    end

    // Next-state, bus and write-back logic
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        ld_buf_d    = ld_buf_q;
        stall       = 1'b0;
`ifdef ACCESS_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                stall = acc;
                if (acc) begin
                    state_d     = ST_REQ;
                    bus_req_d   = 1'b1;
                    bus_we_d    = MEMDramWriteEnable;
                    bus_addr_d  = {MEMAluResult[XLEN-1:2], 2'b00};
                    bus_wdata_d = MEMRegisterData2;
`ifdef ACCESS_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (bus_ack) begin
                    ld_buf_d  = bus_rdata;
                    bus_req_d = 1'b0;
                    state_d   = ST_DONE;
                end
`ifdef ACCESS_TIMEOUT_EN
                else if (cnt_q == CNTW'(TIMEOUT_CYCLES - 1)) begin
                    ld_buf_d  = '0;
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wb_we_d   = 1'b0;
        wb_reg_d  = wb_reg_q;
        wb_data_d = wb_data_q;
        if (!stall) begin
            wb_we_d   = MEMRegisterFileWriteEnable;
            wb_reg_d  = MEMWriteRegister;
            wb_data_d = wb_mux;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bus, load buffer and MEM/WB registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            ld_buf_q    <= '0;
            wb_we_q     <= 1'b0;
            wb_reg_q    <= '0;
            wb_data_q   <= '0;
        end else begin
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            ld_buf_q    <= ld_buf_d;
            wb_we_q     <= wb_we_d;
            wb_reg_q    <= wb_reg_d;
            wb_data_q   <= wb_data_d;
        end
    end

`ifdef ACCESS_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign MEMBusError = err_q;
`else
    assign MEMBusError = 1'b0;
`endif

    assign MEMStall                  = stall;
    assign bus_req                   = bus_req_q;
    assign bus_we                    = bus_we_q;
    assign bus_addr                  = bus_addr_q;
    assign bus_wdata                 = bus_wdata_q;
    assign WBRegisterFileWriteEnable = wb_we_q;
    assign WBWriteRegister           = wb_reg_q;
    assign WBWriteData               = wb_data_q;

endmodule
